// File: rtl/sha256_dma_pkg.sv
// rtl/sha256_dma_pkg.sv - shared types and constants for the SHA256 DMA read path
package sha256_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BUS     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ALIGN   = 2'd3;

    localparam logic [7:0] RSEL_FULL   = 8'hFF;
    localparam logic [3:0] RLEN_SINGLE = 4'h1;
    localparam int         BEAT_BYTES  = 8;

endpackage

// File: rtl/sha256_dma_reader.sv
// rtl/sha256_dma_reader.sv - single-beat 64-bit read initiator feeding the SHA256 loader (optional SHA256_DMA_RD_TIMEOUT_EN)
module sha256_dma_reader
    import sha256_dma_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             axi_clk_i,
    input  logic             axi_rst_i,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [63:0]      dat_o,
    output logic             dat_valid_o,
    output logic [31:0]      axi_raddr_o,
    output logic             axi_rvalid_o,
    output logic [7:0]       axi_rsel_o,
    output logic [3:0]       axi_rlen_o,
    output logic             axi_rfixed_o,
    input  logic [63:0]      axi_rdata_i,
    input  logic             axi_rrdy_i,
    input  logic             axi_rerr_i
);

    state_t           state;
    logic [LEN_W-1:0] remaining;

    assign axi_rsel_o   = RSEL_FULL;
    assign axi_rlen_o   = RLEN_SINGLE;
    assign axi_rfixed_o = 1'b0;

`ifdef SHA256_DMA_RD_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [TCNT_W-1:0] tcnt;
    logic              timeout_hit;
    assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // Transfer sequencer: four-phase request/release per beat, all outputs registered
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state        <= IDLE;
            remaining    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            err_code_o   <= ERR_NONE;
            dat_o        <= '0;
            dat_valid_o  <= 1'b0;
            axi_raddr_o  <= '0;
            axi_rvalid_o <= 1'b0;
`ifdef SHA256_DMA_RD_TIMEOUT_EN
            tcnt         <= '0;
`endif
        end else begin
            done_o      <= 1'b0;
            dat_valid_o <= 1'b0;
`ifdef SHA256_DMA_RD_TIMEOUT_EN
            // Any cycle that does not explicitly keep waiting restarts the count
            tcnt        <= '0;
`endif
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o     <= 1'b1;
                        err_o      <= 1'b0;
                        err_code_o <= ERR_NONE;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (base_addr_i[2:0] != 3'b000) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_ALIGN;
                            state      <= DONE;
                            done_o     <= 1'b1;
                        end else begin
                            remaining    <= len_i;
                            axi_raddr_o  <= base_addr_i;
                            axi_rvalid_o <= 1'b1;
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (axi_rerr_i) begin
                        axi_rvalid_o <= 1'b0;
                        err_o        <= 1'b1;
                        err_code_o   <= ERR_BUS;
                        state        <= DONE;
                        done_o       <= 1'b1;
                    end else if (axi_rrdy_i) begin
                        dat_o        <= axi_rdata_i;
                        dat_valid_o  <= 1'b1;
                        axi_rvalid_o <= 1'b0;
                        remaining    <= remaining - 1'b1;
                        state        <= REL;
                    end
`ifdef SHA256_DMA_RD_TIMEOUT_EN
                    else if (timeout_hit) begin
                        axi_rvalid_o <= 1'b0;
                        err_o        <= 1'b1;
                        err_code_o   <= ERR_TIMEOUT;
                        state        <= DONE;
                        done_o       <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                REL: begin
                    if (!axi_rrdy_i) begin
                        if (remaining == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            // Address wraps modulo 2^32 by design
                            axi_raddr_o  <= axi_raddr_o + 32'(BEAT_BYTES);
                            axi_rvalid_o <= 1'b1;
                            state        <= REQ;
                        end
                    end
`ifdef SHA256_DMA_RD_TIMEOUT_EN
                    else if (timeout_hit) begin
                        err_o      <= 1'b1;
                        err_code_o <= ERR_TIMEOUT;
                        state      <= DONE;
                        done_o     <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_dma_reader.sv
// tb/tb_sha256_dma_reader.sv - directed self-checking bench for sha256_dma_reader
module tb_sha256_dma_reader;

    localparam int LEN_W = 8;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [31:0]      base_addr_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o, done_o, err_o, dat_valid_o, axi_rvalid_o, axi_rfixed_o;
    logic [1:0]       err_code_o;
    logic [63:0]      dat_o;
    logic [31:0]      axi_raddr_o;
    logic [7:0]       axi_rsel_o;
    logic [3:0]       axi_rlen_o;
    logic [63:0]      axi_rdata_i = '0;
    logic             axi_rrdy_i = 1'b0;
    logic             axi_rerr_i = 1'b0;

    sha256_dma_reader #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
        .axi_clk_i(clk), .axi_rst_i(rst), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .dat_o(dat_o), .dat_valid_o(dat_valid_o),
        .axi_raddr_o(axi_raddr_o), .axi_rvalid_o(axi_rvalid_o),
        .axi_rsel_o(axi_rsel_o), .axi_rlen_o(axi_rlen_o), .axi_rfixed_o(axi_rfixed_o),
        .axi_rdata_i(axi_rdata_i), .axi_rrdy_i(axi_rrdy_i), .axi_rerr_i(axi_rerr_i)
    );

    always #5 clk = ~clk;

    // Memory responder: 1-cycle latency, four-phase handshake, optional error address / stall
    logic [63:0] mem [0:31];
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = '0;
    logic        stall    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            axi_rrdy_i <= 1'b0;
            axi_rerr_i <= 1'b0;
        end else begin
            axi_rerr_i  <= axi_rvalid_o && err_en && (axi_raddr_o == err_addr);
            axi_rrdy_i  <= axi_rvalid_o && !stall && !(err_en && (axi_raddr_o == err_addr));
            axi_rdata_i <= mem[axi_raddr_o[7:3]];
        end
    end

    // Observation of pulses away from the active edge
    int          cyc = 0;
    int          dv_cnt = 0, done_cnt = 0, rv_cnt = 0, bad_gap = 0, last_dv = 0;
    logic [63:0] words [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dat_valid_o) begin
            if (dv_cnt > 0 && (cyc - last_dv) != 4) bad_gap++;
            if (dv_cnt < 32) words[dv_cnt] = dat_o;
            last_dv = cyc;
            dv_cnt++;
        end
        if (done_o) done_cnt++;
        if (axi_rvalid_o) rv_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        @(negedge clk);
        dv_cnt = 0; done_cnt = 0; rv_cnt = 0; bad_gap = 0;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [LEN_W-1:0] len);
        @(negedge clk);
        start_i = 1'b1; base_addr_i = base; len_i = len;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(posedge clk);
            if (done_cnt > 0) break;
        end
        if (k == max_cyc) check({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {32'hA5A50000, 32'h10000000 + 32'(i * 8)};
        mem[0]  = 64'h81cd02ab_01000000;
        mem[10] = 64'h00000000_80000000;
        mem[15] = 64'h00000280_00000000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_rvalid", 64'(axi_rvalid_o), 64'd0);
        check("rst_err", {62'd0, err_code_o}, 64'd0);
        check("rst_dat", dat_o, 64'd0);
        check("const_bus", {51'd0, axi_rsel_o, axi_rlen_o, axi_rfixed_o}, {51'd0, 8'hFF, 4'h1, 1'b0});
        @(negedge clk) rst = 1'b0;

        // 16-beat transfer
        clear_obs();
        do_start(32'h10000000, 8'd16);
        check("t1_rvalid_rise", 64'(axi_rvalid_o), 64'd1);
        check("t1_raddr", 64'(axi_raddr_o), 64'h10000000);
        wait_done("t1", 200);
        check("t1_beats", 64'(dv_cnt), 64'd16);
        check("t1_gap", 64'(bad_gap), 64'd0);
        check("t1_first", words[0], 64'h81cd02ab_01000000);
        check("t1_11th", words[10], 64'h00000000_80000000);
        check("t1_last", words[15], 64'h00000280_00000000);
        check("t1_done", 64'(done_cnt), 64'd1);
        check("t1_err", 64'(err_o), 64'd0);
        check("t1_busy_end", 64'(busy_o), 64'd0);

        // bus error on second beat
        clear_obs();
        err_en = 1'b1; err_addr = 32'h10000080;
        do_start(32'h10000078, 8'd2);
        wait_done("t2", 100);
        err_en = 1'b0;
        check("t2_beats", 64'(dv_cnt), 64'd1);
        check("t2_word", words[0], 64'h00000280_00000000);
        check("t2_err", 64'(err_o), 64'd1);
        check("t2_code", {62'd0, err_code_o}, 64'd1);
        check("t2_done", 64'(done_cnt), 64'd1);
        check("t2_rvalid", 64'(axi_rvalid_o), 64'd0);

        // misaligned base
        clear_obs();
        do_start(32'h10000004, 8'd4);
        check("t3_done_next", 64'(done_o), 64'd1);
        check("t3_code", {62'd0, err_code_o}, 64'd3);
        wait_done("t3", 20);
        check("t3_no_bus", 64'(rv_cnt), 64'd0);
        check("t3_err", 64'(err_o), 64'd1);
        clear_obs();
        do_start(32'h10000000, 8'd1);
        check("t3_err_clr", 64'(err_o), 64'd0);
        wait_done("t3b", 50);
        check("t3b_beats", 64'(dv_cnt), 64'd1);

        // zero length, then start pulsed while busy
        clear_obs();
        do_start(32'h10000000, 8'd0);
        wait_done("t4", 20);
        check("t4_done", 64'(done_cnt), 64'd1);
        check("t4_no_bus", 64'(rv_cnt), 64'd0);
        check("t4_err", 64'(err_o), 64'd0);
        clear_obs();
        do_start(32'h10000000, 8'd3);
        repeat (5) @(negedge clk);
        start_i = 1'b1; len_i = 8'd8;
        @(negedge clk) start_i = 1'b0;
        wait_done("t4b", 100);
        check("t4b_beats", 64'(dv_cnt), 64'd3);
        check("t4b_done", 64'(done_cnt), 64'd1);

        // reset during REQ of beat 5
        clear_obs();
        do_start(32'h10000000, 8'd16);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (dv_cnt == 4 && axi_rvalid_o) break;
            end
            if (k == 100) check("t5_reach_beat5", 64'd0, 64'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rvalid", 64'(axi_rvalid_o), 64'd0);
        check("t5_busy", 64'(busy_o), 64'd0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);
        check("t5_no_done", 64'(done_cnt), 64'd0);
        clear_obs();
        do_start(32'h10000000, 8'd2);
        wait_done("t5b", 50);
        check("t5b_beats", 64'(dv_cnt), 64'd2);
        check("t5b_done", 64'(done_cnt), 64'd1);

`ifdef SHA256_DMA_RD_TIMEOUT_EN
        // stalled responder: timeout after TO cycles in REQ
        clear_obs();
        stall = 1'b1;
        do_start(32'h10000000, 8'd4);
        begin
            int k;
            for (k = 1; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (done_o) break;
            end
            check("t6_latency", 64'(k), 64'(TO));
        end
        check("t6_code", {62'd0, err_code_o}, 64'd2);
        check("t6_rvalid", 64'(axi_rvalid_o), 64'd0);
        check("t6_err", 64'(err_o), 64'd1);
        stall = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
